// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch, data load/store and a loader.
// Grants are combinational; the response pulse follows one cycle later from the owner register.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_done,

    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        stall
);

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;
    localparam int unsigned MAW = 30;
    localparam int unsigned SCW = 2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_L    = 2'd3;

    localparam logic [SCW-1:0] STARVE_MAX = SCW'(3);

    logic [1:0]     owner_q, owner_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic           starve_hit;

    // Word addressing only; byte offsets are the requester's concern.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0], l_addr[1:0]};

    // Fixed priority loader > data > fetch, with a starved fetch jumping ahead of data.
    always_comb begin
        l_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_gnt      = 1'b0;
        starve_hit = (starve_q == STARVE_MAX) && !l_req;
        if (!reset) begin
            if (l_req) begin
                l_gnt = 1'b1;
            end else if (i_req && starve_hit) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // RAM port steering from the granted requester.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = BEW'(0);
        mem_addr  = MAW'(0);
        mem_wdata = DW'(0);
        if (l_gnt) begin
            mem_en    = 1'b1;
            mem_we    = {BEW{1'b1}};
            mem_addr  = l_addr[31:2];
            mem_wdata = l_wdata;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we ? d_be : BEW'(0);
            mem_addr  = d_addr[31:2];
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr[31:2];
        end
    end

    // Next owner and starvation count.
    always_comb begin
        owner_d  = OWN_NONE;
        starve_d = starve_q;
        if (l_gnt) begin
            owner_d = OWN_L;
        end else if (d_gnt) begin
            owner_d = OWN_D;
        end else if (i_gnt) begin
            owner_d = OWN_I;
        end

        if (i_gnt) begin
            starve_d = SCW'(0);
        end else if (i_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            starve_q <= SCW'(0);
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Responses are gated by reset so a grant cancelled by reset never reports.
    assign i_rvalid = !reset && (owner_q == OWN_I);
    assign d_rvalid = !reset && (owner_q == OWN_D);
    assign l_done   = !reset && (owner_q == OWN_L);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    assign stall = !reset && ((i_req && !i_gnt) || (d_req && !d_gnt) || l_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven on the falling edge,
// outputs checked 1 ns later, expectations hand-computed per step.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        l_req;
    logic [31:0] l_addr, l_wdata;
    logic        l_gnt, l_done;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        stall;

    int vectors = 0;
    int errors  = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_done(l_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
        d_we = 1'b0; d_be = 4'b0000;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Checks every output that must be quiet.
    task automatic chk_quiet(input string tag);
        chk({tag, ".i_gnt"},    32'(i_gnt),    32'd0);
        chk({tag, ".d_gnt"},    32'(d_gnt),    32'd0);
        chk({tag, ".l_gnt"},    32'(l_gnt),    32'd0);
        chk({tag, ".mem_en"},   32'(mem_en),   32'd0);
        chk({tag, ".mem_we"},   32'(mem_we),   32'd0);
        chk({tag, ".i_rvalid"}, 32'(i_rvalid), 32'd0);
        chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'd0);
        chk({tag, ".l_done"},   32'(l_done),   32'd0);
        chk({tag, ".stall"},    32'(stall),    32'd0);
    endtask

    bit exp_i_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b1; idle();
        i_addr = '0; d_addr = '0; d_wdata = '0; l_addr = '0; l_wdata = '0; mem_rdata = '0;

        // Reset dominates even with every request raised.
        next_cycle();
        i_req = 1'b1; d_req = 1'b1; l_req = 1'b1;
        #1 chk_quiet("rst_all_req");
        next_cycle();
        idle();
        #1 chk_quiet("rst_idle");
        next_cycle();
        reset = 1'b0;
        #1 chk_quiet("post_rst_idle");

        // Lone fetch and its response.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0000_0010;
        #1;
        chk("fetch.i_gnt",    32'(i_gnt),    32'd1);
        chk("fetch.mem_en",   32'(mem_en),   32'd1);
        chk("fetch.mem_addr", 32'(mem_addr), 32'h4);
        chk("fetch.mem_we",   32'(mem_we),   32'd0);
        chk("fetch.stall",    32'(stall),    32'd0);
        next_cycle();
        idle(); mem_rdata = 32'h0000_0013;
        #1;
        chk("fetch.i_rvalid", 32'(i_rvalid), 32'd1);
        chk("fetch.i_rdata",  i_rdata,       32'h0000_0013);
        chk("fetch.d_rvalid", 32'(d_rvalid), 32'd0);
        next_cycle();
        #1 chk_quiet("fetch_after");

        // Store beats fetch; fetch follows next cycle.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0000_0020;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0102; d_wdata = 32'hAABB_CCDD;
        #1;
        chk("st.d_gnt",     32'(d_gnt),     32'd1);
        chk("st.i_gnt",     32'(i_gnt),     32'd0);
        chk("st.mem_we",    32'(mem_we),    32'b0011);
        chk("st.mem_addr",  32'(mem_addr),  32'h40);
        chk("st.mem_wdata", mem_wdata,      32'hAABB_CCDD);
        chk("st.stall",     32'(stall),     32'd1);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0; d_be = 4'b0000;
        #1;
        chk("st2.i_gnt",    32'(i_gnt),    32'd1);
        chk("st2.mem_addr", 32'(mem_addr), 32'h8);
        chk("st2.d_rvalid", 32'(d_rvalid), 32'd1);
        chk("st2.stall",    32'(stall),    32'd0);
        next_cycle();
        idle(); mem_rdata = 32'h1111_2222;
        #1;
        chk("st3.i_rvalid", 32'(i_rvalid), 32'd1);
        chk("st3.d_rvalid", 32'(d_rvalid), 32'd0);

        // Data and fetch contend: starvation lets fetch in on the 4th cycle.
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            i_req = 1'b1; i_addr = 32'h0000_0300;
            d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h0000_0200;
            #1;
            chk($sformatf("starve%0d.i_gnt", k), 32'(i_gnt), 32'(exp_i_pat[k]));
            chk($sformatf("starve%0d.d_gnt", k), 32'(d_gnt), 32'(!exp_i_pat[k]));
            chk($sformatf("starve%0d.stall", k), 32'(stall), 32'd1);
            if (k > 0) begin
                chk($sformatf("starve%0d.i_rvalid", k), 32'(i_rvalid), 32'(exp_i_pat[k-1]));
                chk($sformatf("starve%0d.d_rvalid", k), 32'(d_rvalid), 32'(!exp_i_pat[k-1]));
            end
        end

        // Counter now at 3: loader still wins, and fetch follows once it leaves.
        next_cycle();
        l_req = 1'b1; l_addr = 32'h0000_1000; l_wdata = 32'hDEAD_BEEF;
        #1;
        chk("ld.l_gnt",     32'(l_gnt),     32'd1);
        chk("ld.d_gnt",     32'(d_gnt),     32'd0);
        chk("ld.i_gnt",     32'(i_gnt),     32'd0);
        chk("ld.mem_we",    32'(mem_we),    32'b1111);
        chk("ld.mem_addr",  32'(mem_addr),  32'h400);
        chk("ld.mem_wdata", mem_wdata,      32'hDEAD_BEEF);
        chk("ld.stall",     32'(stall),     32'd1);
        next_cycle();
        l_req = 1'b0;
        #1;
        chk("ld2.l_done", 32'(l_done), 32'd1);
        chk("ld2.i_gnt",  32'(i_gnt),  32'd1);
        chk("ld2.d_gnt",  32'(d_gnt),  32'd0);
        chk("ld2.stall",  32'(stall),  32'd1);
        next_cycle();
        idle();
        #1;
        chk("ld3.i_rvalid", 32'(i_rvalid), 32'd1);
        chk("ld3.l_done",   32'(l_done),   32'd0);

        // Zero byte-enable store is a granted no-op that still responds.
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0000; d_addr = 32'h0000_0050;
        #1;
        chk("nop.d_gnt",  32'(d_gnt),  32'd1);
        chk("nop.mem_en", 32'(mem_en), 32'd1);
        chk("nop.mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        idle();
        #1 chk("nop.d_rvalid", 32'(d_rvalid), 32'd1);

        // Reset right after a load grant cancels its response.
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h0000_0060;
        #1 chk("rc.d_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        idle(); reset = 1'b1;
        #1 chk("rc.d_rvalid", 32'(d_rvalid), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1 chk_quiet("rc_release");
        next_cycle();
        #1 chk_quiet("rc_release2");

        // Alternating load / fetch at full throughput.
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            idle();
            mem_rdata = 32'hC0DE_0000 + 32'(k);
            if (k < 8) begin
                if (k % 2 == 0) begin
                    d_req = 1'b1; d_be = 4'b1111; d_addr = 32'h0000_0400 + 32'(4 * k);
                end else begin
                    i_req = 1'b1; i_addr = 32'h0000_0800 + 32'(4 * k);
                end
            end
            #1;
            if (k < 8) begin
                chk($sformatf("alt%0d.d_gnt", k), 32'(d_gnt), 32'(k % 2 == 0));
                chk($sformatf("alt%0d.i_gnt", k), 32'(i_gnt), 32'(k % 2 == 1));
            end
            if (k > 0) begin
                chk($sformatf("alt%0d.d_rvalid", k), 32'(d_rvalid), 32'((k - 1) % 2 == 0));
                chk($sformatf("alt%0d.i_rvalid", k), 32'(i_rvalid), 32'((k - 1) % 2 == 1));
                if ((k - 1) % 2 == 0) chk($sformatf("alt%0d.d_rdata", k), d_rdata, 32'hC0DE_0000 + 32'(k));
                else                  chk($sformatf("alt%0d.i_rdata", k), i_rdata, 32'hC0DE_0000 + 32'(k));
            end
        end
        next_cycle();
        #1 chk_quiet("alt_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
